// File: rtl/passcode_checker_pkg.sv
// Shared types for the alarm system FSM and the keypad passcode checker.
package passcode_checker_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_SET,
    STATE_TRIGGER,
    STATE_ALARM
  } fsm_state_t;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_COLLECT,
    PC_CHECK,
    PC_LOCKOUT
  } pc_state_t;

  localparam int TIMER_W = 32;

  // Entry is only meaningful while the system is armed or already tripped.
  function automatic logic is_armed(input fsm_state_t s);
    return (s == STATE_SET) || (s == STATE_TRIGGER);
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an active-low button plus a registered falling-edge pulse.
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync_p0, sync_p1, prev_p2;

  // Stage 0/1: synchronizer, stage 2: edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      press   <= prev_p2 & ~sync_p1;
    end
  end

endmodule

// File: rtl/passcode_checker.sv
// Keypad passcode checker: buffers entered digits, pulses correct/wrong, and
// enforces a timed lockout after repeated wrong codes while the system is armed.
module passcode_checker
  import passcode_checker_pkg::*;
#(
  parameter int                           CODE_LEN        = 4,
  parameter int                           DIGIT_W         = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  PASSCODE        = 16'h1234,
  parameter int                           CLK_HZ          = 50000000,
  parameter int                           ENTRY_TIMEOUT_S = 5,
  parameter int                           MAX_FAILS       = 3,
  parameter int                           LOCKOUT_S       = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  fsm_state_t                       system_state,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             enter_n,
  input  logic                             clear_n,
  output logic                             passcode_correct,
  output logic                             passcode_wrong,
  output logic [$clog2(CODE_LEN+1)-1:0]    digits_entered,
  output logic                             locked_out
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_CYC = TIMER_W'(ENTRY_TIMEOUT_S * CLK_HZ);
  localparam logic [TIMER_W-1:0] LOCKOUT_CYC = TIMER_W'(LOCKOUT_S * CLK_HZ);

  logic               enter_press, clear_press;
  logic [DIGIT_W-1:0] digit_p0, digit_p1;

  pc_state_t          state_q, state_d;
  logic [CODE_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;

  button_sync u_enter_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (enter_n),
    .press (enter_press)
  );

  button_sync u_clear_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (clear_n),
    .press (clear_press)
  );

  // Stage 0/1: digit synchronizer, aligned with the button edge register output
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_p0 <= '0;
      digit_p1 <= '0;
    end else begin
      digit_p0 <= digit_in;
      digit_p1 <= digit_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PC_IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      timer_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    if (!is_armed(system_state)) begin
      state_d = PC_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      fail_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        PC_IDLE: begin
          state_d = PC_COLLECT;
          timer_d = '0;
        end
        PC_COLLECT: begin
          // Clear has priority: a simultaneous digit press is discarded.
          if (clear_press) begin
            buf_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
          end else if (enter_press) begin
            buf_d   = (buf_q << DIGIT_W) | CODE_W'(digit_p1);
            timer_d = '0;
            if (cnt_q == CNT_W'(CODE_LEN - 1)) begin
              cnt_d   = CNT_W'(CODE_LEN);
              state_d = PC_CHECK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (cnt_q != '0) begin
            if (timer_q >= TIMEOUT_CYC - TIMER_W'(1)) begin
              buf_d   = '0;
              cnt_d   = '0;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        PC_CHECK: begin
          buf_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = PC_COLLECT;
          if (buf_q == PASSCODE) begin
            correct_d = 1'b1;
            fail_d    = '0;
          end else begin
            wrong_d = 1'b1;
            if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
              fail_d  = FAIL_W'(MAX_FAILS);
              state_d = PC_LOCKOUT;
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end
        end
        PC_LOCKOUT: begin
          if (timer_q >= LOCKOUT_CYC - TIMER_W'(1)) begin
            fail_d  = '0;
            timer_d = '0;
            state_d = PC_COLLECT;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = PC_IDLE;
      endcase
    end
  end

  assign passcode_correct = correct_q;
  assign passcode_wrong   = wrong_q;
  assign digits_entered   = cnt_q;
  assign locked_out       = (state_q == PC_LOCKOUT);

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: reference vectors, hand-built corner sequences,
// and randomized codes checked against a code-level model.
module tb_passcode_checker;
  import passcode_checker_pkg::*;

  localparam int          CODE_LEN        = 4;
  localparam int          DIGIT_W         = 4;
  localparam logic [15:0] PASSCODE        = 16'h1234;
  localparam int          CLK_HZ          = 10;
  localparam int          ENTRY_TIMEOUT_S = 2;
  localparam int          MAX_FAILS       = 3;
  localparam int          LOCKOUT_S       = 3;
  localparam int          LOCK_CYC        = LOCKOUT_S * CLK_HZ;

  logic         clk = 1'b0;
  logic         rst;
  fsm_state_t   system_state;
  logic [3:0]   digit_in;
  logic         enter_n, clear_n;
  logic         passcode_correct, passcode_wrong;
  logic [2:0]   digits_entered;
  logic         locked_out;

  always #5 clk = ~clk;

  passcode_checker #(
    .CODE_LEN        (CODE_LEN),
    .DIGIT_W         (DIGIT_W),
    .PASSCODE        (PASSCODE),
    .CLK_HZ          (CLK_HZ),
    .ENTRY_TIMEOUT_S (ENTRY_TIMEOUT_S),
    .MAX_FAILS       (MAX_FAILS),
    .LOCKOUT_S       (LOCKOUT_S)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .system_state     (system_state),
    .digit_in         (digit_in),
    .enter_n          (enter_n),
    .clear_n          (clear_n),
    .passcode_correct (passcode_correct),
    .passcode_wrong   (passcode_wrong),
    .digits_entered   (digits_entered),
    .locked_out       (locked_out)
  );

  int   n_cmp = 0, n_fail = 0;
  int   n_c = 0, n_w = 0, n_lk = 0, n_dbl = 0;
  logic prev_c = 1'b0, prev_w = 1'b0;

  // Running tallies of output activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (passcode_correct) n_c <= n_c + 1;
    if (passcode_wrong) n_w <= n_w + 1;
    if (locked_out) n_lk <= n_lk + 1;
    if ((passcode_correct && prev_c) || (passcode_wrong && prev_w)) n_dbl <= n_dbl + 1;
    prev_c <= passcode_correct;
    prev_w <= passcode_wrong;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input bit with_clear);
    digit_in = d;
    tick(2);
    enter_n = 1'b0;
    if (with_clear) clear_n = 1'b0;
    tick(4);
    enter_n = 1'b1;
    clear_n = 1'b1;
    tick(6);
  endtask

  task automatic do_code(input logic [15:0] code, input bit active, input string name);
    for (int i = 0; i < CODE_LEN; i++) begin
      press(code[15-4*i -: 4], 1'b0);
      check($sformatf("%s cnt%0d", name, i), int'(digits_entered),
            (active && i < CODE_LEN - 1) ? i + 1 : 0);
    end
  endtask

  task automatic wait_unlock(input string name);
    int k;
    k = 0;
    while (locked_out && k < 100) begin
      tick(1);
      k++;
    end
    check({name, " unlock"}, int'(locked_out), 0);
  endtask

  typedef struct {
    fsm_state_t  st;
    logic [15:0] code;
    int          exp_c;
    int          exp_w;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          c0, w0, lk0, fails, pick;
    fsm_state_t  st;
    logic [15:0] code;
    bit          act, ok;

    tbl[0] = '{STATE_SET,     16'h1234, 1, 0};
    tbl[1] = '{STATE_TRIGGER, 16'h1235, 0, 1};
    tbl[2] = '{STATE_SET,     16'h1234, 1, 0};
    tbl[3] = '{STATE_IDLE,    16'h1234, 0, 0};
    tbl[4] = '{STATE_SET,     16'h9999, 0, 1};
    tbl[5] = '{STATE_ALARM,   16'h1234, 0, 0};
    tbl[6] = '{STATE_TRIGGER, 16'h4321, 0, 1};
    tbl[7] = '{STATE_TRIGGER, 16'h1234, 1, 0};

    rst = 1'b1;
    system_state = STATE_IDLE;
    digit_in = 4'h0;
    enter_n = 1'b1;
    clear_n = 1'b1;
    tick(3);
    system_state = STATE_SET;
    tick(2);
    check("reset correct", int'(passcode_correct), 0);
    check("reset wrong", int'(passcode_wrong), 0);
    check("reset cnt", int'(digits_entered), 0);
    check("reset locked", int'(locked_out), 0);
    rst = 1'b0;
    tick(3);

    for (int i = 0; i < 8; i++) begin
      system_state = tbl[i].st;
      tick(3);
      c0 = n_c;
      w0 = n_w;
      do_code(tbl[i].code, is_armed(tbl[i].st), $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d correct", i), n_c - c0, tbl[i].exp_c);
      check($sformatf("tbl%0d wrong", i), n_w - w0, tbl[i].exp_w);
      check($sformatf("tbl%0d locked", i), int'(locked_out), 0);
    end

    // Partial entry abandoned by inactivity
    system_state = STATE_SET;
    tick(3);
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    check("timeout cnt2", int'(digits_entered), 2);
    tick(8);
    check("timeout before", int'(digits_entered), 2);
    tick(10);
    check("timeout after", int'(digits_entered), 0);
    c0 = n_c;
    do_code(16'h1234, 1'b1, "timeout code");
    check("timeout correct", n_c - c0, 1);

    // Clear and enter together; fail count must be preserved
    system_state = STATE_TRIGGER;
    tick(3);
    w0 = n_w;
    do_code(16'h1235, 1'b1, "clr wrong1");
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    check("clr cnt2", int'(digits_entered), 2);
    press(4'h3, 1'b1);
    check("clr cnt0", int'(digits_entered), 0);
    do_code(16'h1235, 1'b1, "clr wrong2");
    check("clr not locked", int'(locked_out), 0);
    do_code(16'h9999, 1'b1, "clr wrong3");
    check("clr locked", int'(locked_out), 1);
    check("clr wrongs", n_w - w0, 3);
    system_state = STATE_SET;
    tick(2);
    check("lock SET stays", int'(locked_out), 1);
    system_state = STATE_IDLE;
    tick(2);
    check("lock IDLE clears", int'(locked_out), 0);

    // Full lockout cycle with ignored presses
    system_state = STATE_TRIGGER;
    tick(3);
    w0 = n_w;
    do_code(16'h1235, 1'b1, "lk1");
    do_code(16'h1235, 1'b1, "lk2");
    lk0 = n_lk;
    do_code(16'h1235, 1'b1, "lk3");
    check("lk locked", int'(locked_out), 1);
    press(4'h1, 1'b0);
    check("lk press1 cnt", int'(digits_entered), 0);
    press(4'h2, 1'b0);
    check("lk press2 cnt", int'(digits_entered), 0);
    wait_unlock("lk");
    check("lk wrongs", n_w - w0, 3);
    check("lk duration", n_lk - lk0, LOCK_CYC);
    c0 = n_c;
    do_code(16'h1234, 1'b1, "lk after");
    check("lk after correct", n_c - c0, 1);

    // Reset restarts the fail count
    system_state = STATE_SET;
    tick(3);
    do_code(16'h1235, 1'b1, "rst w1");
    do_code(16'h1235, 1'b1, "rst w2");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst cnt", int'(digits_entered), 0);
    tick(3);
    w0 = n_w;
    do_code(16'h1235, 1'b1, "rst w3");
    check("rst wrong", n_w - w0, 1);
    check("rst no lock", int'(locked_out), 0);

    // Randomized codes against a code-level model
    system_state = STATE_IDLE;
    tick(3);
    fails = 0;
    for (int r = 0; r < 25; r++) begin
      pick = int'($urandom_range(0, 9));
      st = (pick < 4) ? STATE_SET : (pick < 8) ? STATE_TRIGGER :
           (pick == 8) ? STATE_IDLE : STATE_ALARM;
      code = ($urandom_range(0, 1) == 1) ? PASSCODE : 16'($urandom);
      act = (st == STATE_SET) || (st == STATE_TRIGGER);
      system_state = st;
      tick(3);
      if (!act) fails = 0;
      c0 = n_c;
      w0 = n_w;
      lk0 = n_lk;
      do_code(code, act, $sformatf("rnd%0d", r));
      ok = (code == PASSCODE);
      if (act) begin
        check($sformatf("rnd%0d correct", r), n_c - c0, ok ? 1 : 0);
        check($sformatf("rnd%0d wrong", r), n_w - w0, ok ? 0 : 1);
        if (ok) fails = 0;
        else fails++;
        if (fails == MAX_FAILS) begin
          check($sformatf("rnd%0d locked", r), int'(locked_out), 1);
          wait_unlock($sformatf("rnd%0d", r));
          check($sformatf("rnd%0d lock len", r), n_lk - lk0, LOCK_CYC);
          fails = 0;
        end else begin
          check($sformatf("rnd%0d unlocked", r), int'(locked_out), 0);
        end
      end else begin
        check($sformatf("rnd%0d idle pulses", r), (n_c - c0) + (n_w - w0), 0);
      end
    end

    check("single-cycle pulses", n_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
